// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one FA cell LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, ps_q, ps_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, busy_q, done_q, fa_sum, fa_cout, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif
  fa u_fa (sa_q[0], sb_q[0], c_q, fa_sum, fa_cout);
  assign ps_d = {fa_sum, ps_q[WIDTH-1:1]};
  assign last = cnt_q == CW'(WIDTH - 1);
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sa_q    <= a;
          sb_q    <= b;
          c_q     <= cin;
          cnt_q   <= '0;
          ps_q    <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          ps_q  <= ps_d;
          c_q   <= fa_cout;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            sum_q   <= ps_d;
            cout_q  <= fa_cout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q is the carry into the MSB slice here
            ovf_q   <= c_q ^ fa_cout;
`endif
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       busy, done, cout;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, cout4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf4;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Leaves the bench at the falling edge of the first RUN cycle.
  task automatic go(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0", busy, done, sum, cout);
    end
    tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      fails++;
      $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b, need 0 0 0 0", busy4, done4, sum4, cout4);
    end
`ifdef SERIAL_ADDER_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b need 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int bc, dc, dpos;
    bc = 0; dc = 0; dpos = 0;
    go(8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        dpos = i;
        tests++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
          fails++;
          $display("FAIL zero_add: sum=%h cout=%b need 00 0", sum, cout);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (bc != 8) begin
      fails++;
      $display("FAIL busy_cycles: got %0d need 8", bc);
    end
    tests++;
    if (dc != 1 || dpos != 9) begin
      fails++;
      $display("FAIL done_pulse: count=%0d at cycle %0d, need 1 at cycle 9", dc, dpos);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [6] = '{8'hFF, 8'h5A, 8'h7F, 8'h80, 8'h3C, 8'hC8};
    logic [7:0] vb [6] = '{8'h01, 8'hA5, 8'h01, 8'h80, 8'h0F, 8'h9C};
    logic       vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [6] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h4C, 8'h64};
    logic       ec [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;
    for (int k = 0; k < 6; k++) begin
      go(va[k], vb[k], vc[k]);
      wait_done(n);
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL vec%0d_timeout: no done after %0d cycles", k, n);
        continue;
      end
      tests++;
      if (sum !== es[k] || cout !== ec[k] || n != 9) begin
        fails++;
        $display("FAIL vec%0d: sum=%h cout=%b at cycle %0d, need %h %b at cycle 9", k, sum, cout, n, es[k], ec[k]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      tests++;
      if (ovf !== eo[k]) begin
        fails++;
        $display("FAIL vec%0d_ovf: got %b need %b", k, ovf, eo[k]);
      end
`else
      if (eo[k] === 1'bx) $display("unexpected table content");
`endif
    end
  endtask

  task automatic test_ignore_start;
    int dc;
    logic hold_ok;
    logic [7:0] cs;
    logic cc;
    dc = 0; hold_ok = 1'b1; cs = '0; cc = 1'b0;
    go(8'h12, 8'h34, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      if (done) begin
        dc++;
        cs = sum;
        cc = cout;
      end else if (dc == 0 && (sum !== 8'h64 || cout !== 1'b1)) hold_ok = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (dc != 1) begin
      fails++;
      $display("FAIL ignore_done_count: got %0d need 1", dc);
    end
    tests++;
    if (cs !== 8'h46 || cc !== 1'b0) begin
      fails++;
      $display("FAIL ignore_result: sum=%h cout=%b need 46 0", cs, cc);
    end
    tests++;
    if (!hold_ok) begin
      fails++;
      $display("FAIL result_hold: sum/cout changed before completion, need 64 1");
    end
  endtask

  task automatic test_async_reset;
    int n, dc;
    go(8'h0F, 8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || sum !== 8'h46) begin
      fails++;
      $display("FAIL pre_reset: busy=%b sum=%h need 1 46", busy, sum);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b need 0 0 00 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    tests++;
    if (dc != 0) begin
      fails++;
      $display("FAIL aborted_done: got %0d pulses need 0", dc);
    end
    go(8'h01, 8'h01, 1'b0);
    wait_done(n);
    tests++;
    if (!done || sum !== 8'h02 || cout !== 1'b0 || n != 9) begin
      fails++;
      $display("FAIL post_reset_add: done=%b sum=%h cout=%b cycle %0d, need 1 02 0 cycle 9", done, sum, cout, n);
    end
  endtask

  // IDLE is visited between results, so held start gives one result every WIDTH+2 cycles.
  task automatic test_sweep;
    int n, cyc, last;
    logic [4:0] e;
    cyc = 0; last = 0;
    @(negedge clk);
    {a4, b4, cin4} = 9'd0;
    start4 = 1'b1;
    for (int k = 0; k < 512; k++) begin
      n = 0;
      while (!done4 && n < 20) begin
        @(negedge clk);
        cyc++;
        n++;
      end
      tests++;
      if (!done4) begin
        fails++;
        $display("FAIL sweep_timeout: vector %0d", k);
        break;
      end
      e = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      tests++;
      if ({cout4, sum4} !== e) begin
        fails++;
        $display("FAIL sweep_sum: %h+%h+%b gave %b_%h need %b_%h", a4, b4, cin4, cout4, sum4, e[4], e[3:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      tests++;
      if (ovf4 !== (a4[3] == b4[3] && e[3] != a4[3])) begin
        fails++;
        $display("FAIL sweep_ovf: %h+%h+%b gave %b", a4, b4, cin4, ovf4);
      end
`endif
      if (k > 0) begin
        tests++;
        if (cyc - last != 6) begin
          fails++;
          $display("FAIL sweep_gap: %0d cycles between results need 6", cyc - last);
        end
      end
      last = cyc;
      {a4, b4, cin4} = 9'(k + 1);
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_latency;
    test_vectors;
    test_ignore_start;
    test_async_reset;
    test_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
